// File: rtl/mem_stage.sv
// Memory stage: turns the ALU result into a data-memory access (or passes it
// through), waits for the req/ack handshake and registers a result for writeback.
module mem_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            VALID_IN,
  input  logic [XLEN-1:0] ALU_RESULT,
  input  logic [XLEN-1:0] STORE_DATA,
  input  logic            MEM_READ,
  input  logic            MEM_WRITE,
  input  logic [1:0]      MEM_SIZE,
  input  logic            MEM_UNSIGNED,
  input  logic [4:0]      RD_IN,
  input  logic            REG_WRITE_IN,
  output logic            STALL,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic [3:0]      DMEM_BE,
  output logic [XLEN-1:0] DMEM_WDATA,
  input  logic [XLEN-1:0] DMEM_RDATA,
  input  logic            DMEM_ACK,
  output logic            WB_VALID,
  output logic [XLEN-1:0] WB_DATA,
  output logic [4:0]      WB_RD,
  output logic            WB_REG_WRITE,
  output logic [1:0]      WB_ERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      off_q, off_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_rw_q, wb_rw_d;
  logic [1:0]      wb_err_q, wb_err_d;

  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] ld_lane;
  logic [XLEN-1:0] ld_data;
  logic            is_mem, illegal, misaligned;
  logic [1:0]      a;

  // Each byte lane picks the store byte that belongs in it, so the memory can
  // simply honour the byte enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_rep[8*gi +: 8] =
        (MEM_SIZE == 2'b00) ? STORE_DATA[7:0] :
        (MEM_SIZE == 2'b01) ? STORE_DATA[8*(gi%2) +: 8] :
                              STORE_DATA[8*gi +: 8];
  end

  assign a          = ALU_RESULT[1:0];
  assign is_mem     = MEM_READ | MEM_WRITE;
  assign illegal    = (MEM_SIZE == 2'b11) | (MEM_READ & MEM_WRITE);
  assign misaligned = ((MEM_SIZE == 2'b01) & a[0]) | ((MEM_SIZE == 2'b10) & (a != 2'b00));

  assign ld_lane = DMEM_RDATA >> {off_q, 3'b000};

  always_comb begin
    ld_data = DMEM_RDATA;
    case (size_q)
      2'b00:   ld_data = uns_q ? {{(XLEN-8){1'b0}}, ld_lane[7:0]}
                               : {{(XLEN-8){ld_lane[7]}}, ld_lane[7:0]};
      2'b01:   ld_data = uns_q ? {{(XLEN-16){1'b0}}, ld_lane[15:0]}
                               : {{(XLEN-16){ld_lane[15]}}, ld_lane[15:0]};
      default: ld_data = DMEM_RDATA;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_rw_d    = wb_rw_q;
    wb_err_d   = wb_err_q;

    case (state_q)
      IDLE: begin
        if (VALID_IN) begin
          wb_rd_d = RD_IN;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ALU_RESULT;
            wb_rw_d    = REG_WRITE_IN;
            wb_err_d   = ERR_OK;
          end else if (illegal || misaligned) begin
            // The faulting address goes to writeback for the trap handler.
            wb_valid_d = 1'b1;
            wb_data_d  = ALU_RESULT;
            wb_rw_d    = 1'b0;
            wb_err_d   = illegal ? ERR_ILLEGAL : ERR_MISALGN;
          end else begin
            req_d   = 1'b1;
            we_d    = MEM_WRITE;
            addr_d  = {ALU_RESULT[XLEN-1:2], 2'b00};
            wdata_d = wdata_rep;
            case (MEM_SIZE)
              2'b00:   be_d = 4'b0001 << a;
              2'b01:   be_d = 4'b0011 << a;
              default: be_d = 4'b1111;
            endcase
            rd_d    = RD_IN;
            rw_d    = REG_WRITE_IN;
            size_d  = MEM_SIZE;
            uns_d   = MEM_UNSIGNED;
            off_d   = a;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (DMEM_ACK) begin
          req_d      = 1'b0;
          be_d       = 4'b0000;
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_err_d   = ERR_OK;
          wb_data_d  = we_q ? '0 : ld_data;
          wb_rw_d    = we_q ? 1'b0 : rw_q;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // This is the last allowed cycle and still no ack: give up.
          req_d      = 1'b0;
          be_d       = 4'b0000;
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_err_d   = ERR_TIMEOUT;
          wb_data_d  = '0;
          wb_rw_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_err_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign STALL        = (state_q == ACCESS);
  assign DMEM_REQ     = req_q;
  assign DMEM_WE      = we_q;
  assign DMEM_ADDR    = addr_q;
  assign DMEM_BE      = be_q;
  assign DMEM_WDATA   = wdata_q;
  assign WB_VALID     = wb_valid_q;
  assign WB_DATA      = wb_data_q;
  assign WB_RD        = wb_rd_q;
  assign WB_REG_WRITE = wb_rw_q;
  assign WB_ERR       = wb_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage; the DUT runs with a 4-cycle bus timeout.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        VALID_IN;
  logic [31:0] ALU_RESULT;
  logic [31:0] STORE_DATA;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [1:0]  MEM_SIZE;
  logic        MEM_UNSIGNED;
  logic [4:0]  RD_IN;
  logic        REG_WRITE_IN;
  logic        STALL;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_WDATA;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic        WB_VALID;
  logic [31:0] WB_DATA;
  logic [4:0]  WB_RD;
  logic        WB_REG_WRITE;
  logic [1:0]  WB_ERR;

  int vectors_applied = 0;
  int miscompares     = 0;

  mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .VALID_IN(VALID_IN), .ALU_RESULT(ALU_RESULT),
    .STORE_DATA(STORE_DATA), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_SIZE(MEM_SIZE), .MEM_UNSIGNED(MEM_UNSIGNED), .RD_IN(RD_IN),
    .REG_WRITE_IN(REG_WRITE_IN), .STALL(STALL), .DMEM_REQ(DMEM_REQ),
    .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .WB_VALID(WB_VALID), .WB_DATA(WB_DATA), .WB_RD(WB_RD),
    .WB_REG_WRITE(WB_REG_WRITE), .WB_ERR(WB_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000ns");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction at a negedge, let it be accepted, then drop VALID_IN.
  task automatic issue(input logic [31:0] addr, input logic [31:0] sdata, input logic rd_en,
                       input logic wr_en, input logic [1:0] size, input logic uns,
                       input logic [4:0] rd, input logic rw);
    VALID_IN = 1'b1; ALU_RESULT = addr; STORE_DATA = sdata; MEM_READ = rd_en;
    MEM_WRITE = wr_en; MEM_SIZE = size; MEM_UNSIGNED = uns; RD_IN = rd; REG_WRITE_IN = rw;
    @(posedge CLK); #1 VALID_IN = 1'b0;
    @(negedge CLK);
  endtask

  // Called at the negedge of the first ACCESS cycle; acks after `waits` idle cycles.
  task automatic run_access(input int waits, input logic [31:0] rdata, output int stall_n);
    stall_n = 0;
    for (int i = 0; i <= waits; i++) begin
      if (STALL) stall_n++;
      if (i == waits) begin DMEM_ACK = 1'b1; DMEM_RDATA = rdata; end
      @(posedge CLK); #1 DMEM_ACK = 1'b0;
      @(negedge CLK);
    end
  endtask

  int n;

  initial begin
    RST_N = 1'b0; VALID_IN = 1'b0; ALU_RESULT = '0; STORE_DATA = '0; MEM_READ = 1'b0;
    MEM_WRITE = 1'b0; MEM_SIZE = 2'b00; MEM_UNSIGNED = 1'b0; RD_IN = '0; REG_WRITE_IN = 1'b0;
    DMEM_RDATA = '0; DMEM_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    check_vec("rst_stall", STALL, 0);
    check_vec("rst_req", DMEM_REQ, 0);
    check_vec("rst_be", DMEM_BE, 0);
    check_vec("rst_wb_valid", WB_VALID, 0);
    check_vec("rst_wb_data", WB_DATA, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Non-memory pass-through.
    issue(32'h0000_0123, 0, 0, 0, 2'b10, 0, 5'd5, 1);
    $display("txn alu 0x123 -> wb 0x%08h rd %0d", WB_DATA, WB_RD);
    check_vec("alu_valid", WB_VALID, 1);
    check_vec("alu_data", WB_DATA, 32'h123);
    check_vec("alu_rd", WB_RD, 5);
    check_vec("alu_rw", WB_REG_WRITE, 1);
    check_vec("alu_err", WB_ERR, 0);
    check_vec("alu_stall", STALL, 0);
    @(negedge CLK);
    check_vec("alu_pulse", WB_VALID, 0);
    check_vec("alu_hold", WB_DATA, 32'h123);

    // LB at 0x1003, three wait cycles.
    issue(32'h0000_1003, 0, 1, 0, 2'b00, 0, 5'd7, 1);
    check_vec("lb_req", DMEM_REQ, 1);
    check_vec("lb_we", DMEM_WE, 0);
    check_vec("lb_addr", DMEM_ADDR, 32'h1000);
    check_vec("lb_be", DMEM_BE, 4'b1000);
    run_access(3, 32'h80FF_FFFF, n);
    $display("txn lb 0x1003 -> wb 0x%08h stall %0d", WB_DATA, n);
    check_vec("lb_stall_n", n, 4);
    check_vec("lb_valid", WB_VALID, 1);
    check_vec("lb_data", WB_DATA, 32'hFFFF_FF80);
    check_vec("lb_rd", WB_RD, 7);
    check_vec("lb_err", WB_ERR, 0);
    check_vec("lb_req_drop", DMEM_REQ, 0);
    check_vec("lb_be_drop", DMEM_BE, 0);
    @(negedge CLK);

    // LBU at 0x1003.
    issue(32'h0000_1003, 0, 1, 0, 2'b00, 1, 5'd8, 1);
    run_access(3, 32'h80FF_FFFF, n);
    $display("txn lbu 0x1003 -> wb 0x%08h", WB_DATA);
    check_vec("lbu_data", WB_DATA, 32'h0000_0080);
    check_vec("lbu_rw", WB_REG_WRITE, 1);
    @(negedge CLK);

    // LH at 0x2002 (signed, upper half).
    issue(32'h0000_2002, 0, 1, 0, 2'b01, 0, 5'd9, 1);
    check_vec("lh_be", DMEM_BE, 4'b1100);
    run_access(0, 32'h9234_5678, n);
    $display("txn lh 0x2002 -> wb 0x%08h", WB_DATA);
    check_vec("lh_data", WB_DATA, 32'hFFFF_9234);
    check_vec("lh_stall_n", n, 1);
    @(negedge CLK);

    // SH at 0x2002.
    issue(32'h0000_2002, 32'hDEAD_BEEF, 0, 1, 2'b01, 0, 5'd10, 1);
    check_vec("sh_we", DMEM_WE, 1);
    check_vec("sh_addr", DMEM_ADDR, 32'h2000);
    check_vec("sh_be", DMEM_BE, 4'b1100);
    check_vec("sh_wdata", DMEM_WDATA, 32'hBEEF_BEEF);
    run_access(1, 32'h0, n);
    $display("txn sh 0x2002 -> err %0d", WB_ERR);
    check_vec("sh_valid", WB_VALID, 1);
    check_vec("sh_rw", WB_REG_WRITE, 0);
    check_vec("sh_err", WB_ERR, 0);
    check_vec("sh_data", WB_DATA, 0);
    @(negedge CLK);

    // SB at 0x0011.
    issue(32'h0000_0011, 32'h1234_56A5, 0, 1, 2'b00, 0, 5'd0, 0);
    check_vec("sb_be", DMEM_BE, 4'b0010);
    check_vec("sb_wdata", DMEM_WDATA, 32'hA5A5_A5A5);
    run_access(0, 32'h0, n);
    $display("txn sb 0x0011 -> err %0d", WB_ERR);
    @(negedge CLK);

    // Misaligned LW.
    issue(32'h0000_3001, 0, 1, 0, 2'b10, 0, 5'd11, 1);
    $display("txn lw 0x3001 -> err %0d", WB_ERR);
    check_vec("mis_req", DMEM_REQ, 0);
    check_vec("mis_stall", STALL, 0);
    check_vec("mis_valid", WB_VALID, 1);
    check_vec("mis_err", WB_ERR, 2'b01);
    check_vec("mis_data", WB_DATA, 32'h3001);
    check_vec("mis_rw", WB_REG_WRITE, 0);

    // Illegal size (also misaligned: illegal wins).
    issue(32'h0000_4001, 0, 1, 0, 2'b11, 0, 5'd12, 1);
    $display("txn size11 0x4001 -> err %0d", WB_ERR);
    check_vec("ill_size_err", WB_ERR, 2'b11);
    check_vec("ill_size_req", DMEM_REQ, 0);
    issue(32'h0000_4000, 0, 1, 1, 2'b10, 0, 5'd12, 1);
    $display("txn rdwr 0x4000 -> err %0d", WB_ERR);
    check_vec("ill_rdwr_err", WB_ERR, 2'b11);
    check_vec("ill_rdwr_rw", WB_REG_WRITE, 0);

    // Timeout: no ack ever.
    issue(32'h0000_5000, 0, 1, 0, 2'b10, 0, 5'd13, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!DMEM_REQ) break;
      n++;
      @(posedge CLK); @(negedge CLK);
    end
    $display("txn lw 0x5000 no ack -> req cycles %0d err %0d", n, WB_ERR);
    check_vec("to_req_n", n, 4);
    check_vec("to_valid", WB_VALID, 1);
    check_vec("to_err", WB_ERR, 2'b10);
    check_vec("to_rw", WB_REG_WRITE, 0);
    check_vec("to_stall", STALL, 0);
    @(negedge CLK);

    // Ack on the timeout cycle wins.
    issue(32'h0000_6000, 0, 1, 0, 2'b10, 0, 5'd14, 1);
    run_access(3, 32'h1234_5678, n);
    $display("txn lw 0x6000 ack@4 -> wb 0x%08h err %0d", WB_DATA, WB_ERR);
    check_vec("ack4_err", WB_ERR, 0);
    check_vec("ack4_data", WB_DATA, 32'h1234_5678);
    check_vec("ack4_rw", WB_REG_WRITE, 1);
    @(negedge CLK);

    // Asynchronous reset during ACCESS, then a late ack.
    issue(32'h0000_7000, 0, 1, 0, 2'b10, 0, 5'd15, 1);
    check_vec("ar_req_before", DMEM_REQ, 1);
    #2 RST_N = 1'b0;
    #1;
    check_vec("ar_req_async", DMEM_REQ, 0);
    check_vec("ar_stall_async", STALL, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFFFF_FFFF;
    @(posedge CLK); #1 DMEM_ACK = 1'b0;
    @(negedge CLK);
    $display("txn reset in access -> wb_valid %0d req %0d", WB_VALID, DMEM_REQ);
    check_vec("ar_late_ack_valid", WB_VALID, 0);
    check_vec("ar_late_ack_req", DMEM_REQ, 0);
    check_vec("ar_late_ack_stall", STALL, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
